// File: rtl/lc3_control_fsm_if.sv
// LC-3 control unit memory port.
// Request/write qualifier out, completion strobe back.
interface lc3_control_fsm_if;
    logic mem_en;
    logic mem_we;
    logic mem_ready;

    modport master (
        output mem_en,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/lc3_control_fsm.sv
// LC-3 multi-cycle control unit.
// Sequences fetch/decode/execute and the memory handshake.
module lc3_control_fsm (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              IR,
    input  logic                     N,
    input  logic                     Z,
    input  logic                     P,
    lc3_control_fsm_if.master        mem,
    output logic                     ldPC,
    output logic                     ldIR,
    output logic                     ldMAR,
    output logic                     ldMDR,
    output logic                     regWE,
    output logic                     flagWE,
    output logic                     enaALU,
    output logic                     enaMARM,
    output logic                     enaPC,
    output logic                     enaMDR,
    output logic                     selEAB1,
    output logic [1:0]               selEAB2,
    output logic [1:0]               selPC,
    output logic                     selMAR,
    output logic                     selMDR,
    output logic [1:0]               aluControl,
    output logic [2:0]               SR1,
    output logic [2:0]               SR2,
    output logic [2:0]               DR,
    output logic                     instr_done,
    output logic                     halted
);

    typedef enum logic [4:0] {
        FETCH0,
        FETCH1,
        FETCH2,
        DECODE,
        EX_ALU,
        EX_BR,
        EX_JMP,
        EX_JSR,
        EX_LEA,
        MEM_ADDR,
        RD_PTR,
        PTR_MAR,
        RD_DATA,
        LD_WB,
        ST_MDR,
        ST_WRITE,
        TRAP_R7,
        TRAP_MAR,
        TRAP_READ,
        TRAP_PC,
        HALT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [3:0] op;
    logic       op_alu;
    logic       op_br;
    logic       op_jmp;
    logic       op_jsr;
    logic       op_lea;
    logic       op_mem;
    logic       op_trap;
    logic       op_halt;
    logic       br_taken;
    logic       unused_ir;

    assign op       = IR[15:12];
    assign op_alu   = (op == 4'b0001) | (op == 4'b0101) | (op == 4'b1001);
    assign op_br    = (op == 4'b0000);
    assign op_jmp   = (op == 4'b1100);
    assign op_jsr   = (op == 4'b0100);
    assign op_lea   = (op == 4'b1110);
    assign op_mem   = (op[1:0] == 2'b10 | op[1:0] == 2'b11)
                    & (op[3:2] != 2'b11) & (op != 4'b1000)
                    & (op != 4'b1001) & (op[1] == 1'b1);
    assign op_trap  = (op == 4'b1111);
    assign op_halt  = (op == 4'b1000) | (op == 4'b1101);
    assign br_taken = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
    assign unused_ir = ^IR[5:3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem.mem_en = 1'b0;
        mem.mem_we = 1'b0;
        ldPC       = 1'b0;
        ldIR       = 1'b0;
        ldMAR      = 1'b0;
        ldMDR      = 1'b0;
        regWE      = 1'b0;
        flagWE     = 1'b0;
        enaALU     = 1'b0;
        enaMARM    = 1'b0;
        enaPC      = 1'b0;
        enaMDR     = 1'b0;
        selEAB1    = 1'b0;
        selEAB2    = 2'b00;
        selPC      = 2'b00;
        selMAR     = 1'b0;
        selMDR     = 1'b0;
        aluControl = 2'b00;
        SR1        = 3'd0;
        SR2        = 3'd0;
        DR         = 3'd0;
        instr_done = 1'b0;
        halted     = 1'b0;
        // Reset blanks every strobe regardless of the registered state.
        if (rst) begin
            unique case (state_q)
                FETCH0: begin
                    enaPC   = 1'b1;
                    ldMAR   = 1'b1;
                    ldPC    = 1'b1;
                    state_d = FETCH1;
                end
                FETCH1: begin
                    mem.mem_en = 1'b1;
                    selMDR     = 1'b1;
                    ldMDR      = mem.mem_ready;
                    if (mem.mem_ready) state_d = FETCH2;
                end
                FETCH2: begin
                    enaMDR  = 1'b1;
                    ldIR    = 1'b1;
                    state_d = DECODE;
                end
                DECODE: begin
                    unique case (1'b1)
                        op_alu:  state_d = EX_ALU;
                        op_br:   state_d = EX_BR;
                        op_jmp:  state_d = EX_JMP;
                        op_jsr:  state_d = EX_JSR;
                        op_lea:  state_d = EX_LEA;
                        op_mem:  state_d = MEM_ADDR;
                        op_trap: state_d = TRAP_R7;
                        op_halt: state_d = HALT;
                        default: state_d = HALT;
                    endcase
                end
                EX_ALU: begin
                    enaALU     = 1'b1;
                    regWE      = 1'b1;
                    flagWE     = 1'b1;
                    DR         = IR[11:9];
                    SR1        = IR[8:6];
                    SR2        = IR[15] ? 3'd0 : IR[2:0];
                    aluControl = IR[15] ? 2'b10
                               : (IR[14] ? 2'b01 : 2'b00);
                    instr_done = 1'b1;
                    state_d    = FETCH0;
                end
                EX_BR: begin
                    if (br_taken) begin
                        ldPC    = 1'b1;
                        selPC   = 2'b01;
                        selEAB2 = 2'b10;
                    end
                    instr_done = 1'b1;
                    state_d    = FETCH0;
                end
                EX_JMP: begin
                    ldPC       = 1'b1;
                    selPC      = 2'b01;
                    selEAB1    = 1'b1;
                    SR1        = IR[8:6];
                    instr_done = 1'b1;
                    state_d    = FETCH0;
                end
                EX_JSR: begin
                    enaPC      = 1'b1;
                    regWE      = 1'b1;
                    DR         = 3'd7;
                    ldPC       = 1'b1;
                    selPC      = 2'b01;
                    if (IR[11]) begin
                        selEAB2 = 2'b11;
                    end else begin
                        selEAB1 = 1'b1;
                        SR1     = IR[8:6];
                    end
                    instr_done = 1'b1;
                    state_d    = FETCH0;
                end
                EX_LEA: begin
                    enaMARM    = 1'b1;
                    selEAB2    = 2'b10;
                    regWE      = 1'b1;
                    DR         = IR[11:9];
                    instr_done = 1'b1;
                    state_d    = FETCH0;
                end
                MEM_ADDR: begin
                    // IR[14] separates base+off6 (LDR/STR) from PC+off9.
                    enaMARM = 1'b1;
                    ldMAR   = 1'b1;
                    selEAB1 = IR[14];
                    selEAB2 = IR[14] ? 2'b01 : 2'b10;
                    SR1     = IR[14] ? IR[8:6] : 3'd0;
                    if (IR[15]) state_d = RD_PTR;
                    else if (IR[12]) state_d = ST_MDR;
                    else state_d = RD_DATA;
                end
                RD_PTR: begin
                    mem.mem_en = 1'b1;
                    selMDR     = 1'b1;
                    ldMDR      = mem.mem_ready;
                    if (mem.mem_ready) state_d = PTR_MAR;
                end
                PTR_MAR: begin
                    enaMDR  = 1'b1;
                    ldMAR   = 1'b1;
                    state_d = IR[12] ? ST_MDR : RD_DATA;
                end
                RD_DATA: begin
                    mem.mem_en = 1'b1;
                    selMDR     = 1'b1;
                    ldMDR      = mem.mem_ready;
                    if (mem.mem_ready) state_d = LD_WB;
                end
                LD_WB: begin
                    enaMDR     = 1'b1;
                    regWE      = 1'b1;
                    flagWE     = 1'b1;
                    DR         = IR[11:9];
                    instr_done = 1'b1;
                    state_d    = FETCH0;
                end
                ST_MDR: begin
                    enaALU     = 1'b1;
                    aluControl = 2'b11;
                    SR1        = IR[11:9];
                    ldMDR      = 1'b1;
                    state_d    = ST_WRITE;
                end
                ST_WRITE: begin
                    mem.mem_en = 1'b1;
                    mem.mem_we = 1'b1;
                    instr_done = mem.mem_ready;
                    if (mem.mem_ready) state_d = FETCH0;
                end
                TRAP_R7: begin
                    enaPC   = 1'b1;
                    regWE   = 1'b1;
                    DR      = 3'd7;
                    state_d = TRAP_MAR;
                end
                TRAP_MAR: begin
                    enaMARM = 1'b1;
                    selMAR  = 1'b1;
                    ldMAR   = 1'b1;
                    state_d = TRAP_READ;
                end
                TRAP_READ: begin
                    mem.mem_en = 1'b1;
                    selMDR     = 1'b1;
                    ldMDR      = mem.mem_ready;
                    if (mem.mem_ready) state_d = TRAP_PC;
                end
                TRAP_PC: begin
                    enaMDR     = 1'b1;
                    ldPC       = 1'b1;
                    selPC      = 2'b10;
                    instr_done = 1'b1;
                    state_d    = FETCH0;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = FETCH0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Randomized scoreboard bench for lc3_control_fsm.
// Behavioural model predicts latency and final-cycle strobes.
module tb_lc3_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] IR = 16'h0;
    logic        N = 1'b0;
    logic        Z = 1'b0;
    logic        P = 1'b0;
    logic        ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE;
    logic        enaALU, enaMARM, enaPC, enaMDR;
    logic        selEAB1, selMAR, selMDR;
    logic [1:0]  selEAB2, selPC, aluControl;
    logic [2:0]  SR1, SR2, DR;
    logic        instr_done, halted;

    lc3_control_fsm_if mem_if ();

    lc3_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .IR         (IR),
        .N          (N),
        .Z          (Z),
        .P          (P),
        .mem        (mem_if),
        .ldPC       (ldPC),
        .ldIR       (ldIR),
        .ldMAR      (ldMAR),
        .ldMDR      (ldMDR),
        .regWE      (regWE),
        .flagWE     (flagWE),
        .enaALU     (enaALU),
        .enaMARM    (enaMARM),
        .enaPC      (enaPC),
        .enaMDR     (enaMDR),
        .selEAB1    (selEAB1),
        .selEAB2    (selEAB2),
        .selPC      (selPC),
        .selMAR     (selMAR),
        .selMDR     (selMDR),
        .aluControl (aluControl),
        .SR1        (SR1),
        .SR2        (SR2),
        .DR         (DR),
        .instr_done (instr_done),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    wire [31:0] outs = {mem_if.mem_en, mem_if.mem_we, ldPC, ldIR,
                        ldMAR, ldMDR, regWE, flagWE,
                        enaALU, enaMARM, enaPC, enaMDR,
                        selEAB1, selEAB2, selPC, selMAR, selMDR,
                        aluControl, SR1, SR2, DR, instr_done, halted};
    localparam logic [31:0] F0_OUTS = 32'h2820_0000;

    typedef struct {
        logic [15:0] ir;
        int          fw;
        int          w;
        logic [2:0]  nzp;
    } stim_t;

    typedef struct packed {
        logic [15:0] ir;
        logic [7:0]  cyc;
        logic        regwe;
        logic        flagwe;
        logic        ldpc;
        logic        memwe;
        logic [1:0]  selpc;
        logic [1:0]  alu;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  bus;
    } exp_t;

    stim_t plan[$];
    exp_t  sbq[$];
    int compared = 0;
    int mismatched = 0;
    int issued = 0;
    int retired = 0;
    int cyc = 0;
    int wcnt = 0;
    int cur_fw = 0;
    int cur_w = 0;
    logic [15:0] cur_ir = 16'h0;
    bit last_en, last_rdy, last_ldir, in_fetch, prev_wait;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency = fixed cost + wait states; final-cycle strobes from the ISA rules.
    function automatic exp_t model(stim_t s);
        exp_t e;
        int base, acc;
        logic [3:0] op;
        e = '0;
        e.ir = s.ir;
        op = s.ir[15:12];
        base = 5;
        acc = 1;
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                e.regwe = 1; e.flagwe = 1; e.bus = 1;
                e.dr = s.ir[11:9]; e.sr1 = s.ir[8:6];
                e.sr2 = (op == 4'b1001) ? 3'd0 : s.ir[2:0];
                e.alu = (op == 4'b0001) ? 2'd0 : (op == 4'b0101) ? 2'd1 : 2'd2;
            end
            4'b0000: begin
                e.ldpc = |(s.ir[11:9] & s.nzp);
                e.selpc = e.ldpc ? 2'd1 : 2'd0;
            end
            4'b1100: begin
                e.ldpc = 1; e.selpc = 1; e.sr1 = s.ir[8:6];
            end
            4'b0100: begin
                e.ldpc = 1; e.selpc = 1; e.regwe = 1; e.dr = 3'd7; e.bus = 3;
                e.sr1 = s.ir[11] ? 3'd0 : s.ir[8:6];
            end
            4'b1110: begin
                e.regwe = 1; e.dr = s.ir[11:9]; e.bus = 2;
            end
            4'b0010, 4'b0110, 4'b1010: begin
                base = (op == 4'b1010) ? 9 : 7;
                acc = (op == 4'b1010) ? 3 : 2;
                e.regwe = 1; e.flagwe = 1; e.dr = s.ir[11:9]; e.bus = 4;
            end
            4'b0011, 4'b0111, 4'b1011: begin
                base = (op == 4'b1011) ? 9 : 7;
                acc = (op == 4'b1011) ? 3 : 2;
                e.memwe = 1;
            end
            4'b1111: begin
                base = 8; acc = 2;
                e.ldpc = 1; e.selpc = 2; e.bus = 4;
            end
            default: ;
        endcase
        e.cyc = 8'(base + s.fw + s.w * (acc - 1));
        return e;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        logic [3:0] ops [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF};
        logic [31:0] r;
        r = $urandom();
        s.ir = {ops[$urandom_range(0, 13)], r[11:0]};
        s.fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        s.w = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        s.nzp = 3'($urandom_range(0, 7));
        return s;
    endfunction

    task automatic issue();
        stim_t s;
        if (plan.size() > 0) s = plan.pop_front();
        else s = rand_stim();
        cur_ir = s.ir;
        cur_fw = s.fw;
        cur_w = s.w;
        {N, Z, P} = s.nzp;
        cyc = 0;
        if (s.ir[15:12] != 4'b1000 && s.ir[15:12] != 4'b1101) begin
            sbq.push_back(model(s));
            issued++;
        end
    endtask

    // Datapath/memory stand-in: loads IR and answers accesses after wait states.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            wcnt = 0; last_en = 0; last_rdy = 0; last_ldir = 0; in_fetch = 0;
            mem_if.mem_ready = 1'b0;
        end else begin
            if (last_ldir) IR = cur_ir;
            if (last_en && last_rdy) begin
                wcnt = 0; in_fetch = 0;
            end else if (last_en) begin
                wcnt++;
            end
            if (enaPC && ldMAR) begin
                issue();
                in_fetch = 1; wcnt = 0;
            end
            mem_if.mem_ready = mem_if.mem_en && (wcnt >= (in_fetch ? cur_fw : cur_w));
            last_en = mem_if.mem_en;
            last_rdy = mem_if.mem_ready;
            last_ldir = ldIR;
        end
    end

    always @(negedge clk) begin
        exp_t e, a;
        int nena;
        if (rst) begin
            cyc++;
            nena = int'(enaALU) + int'(enaMARM) + int'(enaPC) + int'(enaMDR);
            check("invariants", {nena > 1, mem_if.mem_we && !mem_if.mem_en,
                  ldMDR && selMDR && !mem_if.mem_ready, prev_wait && !mem_if.mem_en}, 0);
            prev_wait = mem_if.mem_en && !mem_if.mem_ready;
            if (cur_ir[15:12] == 4'hF && cyc == 5 + cur_fw)
                check("trap_save", {regWE, DR, enaPC, enaALU | enaMARM | enaMDR},
                      {1'b1, 3'd7, 1'b1, 1'b0});
            if (cur_ir[15:12] == 4'hF && cyc == 6 + cur_fw)
                check("trap_vec", {enaMARM, selMAR, ldMAR, enaPC | enaMDR | enaALU},
                      {1'b1, 1'b1, 1'b1, 1'b0});
            if (instr_done) begin
                if (sbq.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL retire: got instr_done ir=%h expected none outstanding", cur_ir);
                end else begin
                    e = sbq.pop_front();
                    a = e;
                    a.cyc = cyc[7:0];
                    a.regwe = regWE; a.flagwe = flagWE; a.ldpc = ldPC;
                    a.memwe = mem_if.mem_we; a.selpc = selPC; a.alu = aluControl;
                    a.dr = DR; a.sr1 = SR1; a.sr2 = SR2;
                    a.bus = enaALU ? 3'd1 : enaMARM ? 3'd2 : enaPC ? 3'd3 : enaMDR ? 3'd4 : 3'd0;
                    check($sformatf("retire ir=%h", e.ir), 64'(a), 64'(e));
                    retired++;
                end
            end
        end else begin
            prev_wait = 0;
        end
    end

    initial begin
        int k;
        int target;
        plan.push_back('{16'hA5F0, 0, 0, 3'b000});
        repeat (3) begin
            @(negedge clk); #1;
            check("reset_outputs", outs, 0);
        end
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); #1;
        check("fetch0_after_reset", outs, F0_OUTS);
        repeat (5) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk); #1;
        check("reset_abort_ldi", outs, 0);
        sbq.delete();
        retired = issued;
        plan.push_back('{16'h1283, 0, 0, 3'b000});
        plan.push_back('{16'h0405, 0, 0, 3'b010});
        plan.push_back('{16'h0405, 0, 0, 3'b100});
        plan.push_back('{16'hA5F0, 0, 3, 3'b000});
        plan.push_back('{16'hF025, 0, 0, 3'b000});
        for (int i = 0; i < 60; i++) plan.push_back(rand_stim());
        plan.push_back('{16'hD000, 0, 0, 3'b000});
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); #1;
        check("fetch0_after_abort", outs, F0_OUTS);

        for (k = 0; k < 20000; k++) begin
            @(negedge clk); #1;
            if (halted) break;
        end
        if (k == 20000) begin
            compared++; mismatched++;
            $display("FAIL halt_timeout: got halted=0 expected halted=1");
        end else begin
            check("halt_cycle", cyc, 5);
            check("all_retired", retired, issued);
        end
        repeat (20) begin
            @(negedge clk); #1;
            check("halt_quiet", outs, 32'h1);
        end

        @(posedge clk); #1; rst = 1'b0;
        sbq.delete();
        retired = issued;
        plan.push_back('{16'h5A7F, 0, 0, 3'b001});
        @(negedge clk); #1;
        check("reset_outputs_halt", outs, 0);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); #1;
        check("fetch0_after_halt", outs, F0_OUTS);
        target = retired + 1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (retired >= target) break;
        end
        if (k == 200) begin
            compared++; mismatched++;
            $display("FAIL recover_timeout: got retired=%0d expected %0d", retired, target);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lc3_control_fsm.md
# lc3_control_fsm

Multi-cycle control unit for the LC-3 datapath. Sequences fetch, decode and execute for the supported LC-3 instruction set by driving every datapath load, enable, select and register-address signal. Runs the memory read/write handshake and takes the branch decision from the datapath N/Z/P flags. Sits beside the datapath inside the LC-3 core, between the datapath and the memory port.

## Interface
Parameters:
- none (LC-3 ISA widths fixed: 16-bit word, 3-bit register address)

Ports:
- clk  in  1  single core clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- IR  in  16  instruction register contents from datapath
- N, Z, P  in  1 each  datapath condition codes
- mem_ready  in  1  memory completes the current access this cycle
- mem_en  out  1  memory access request
- mem_we  out  1  write qualifier for mem_en
- ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE  out  1 each  register load strobes
- enaALU, enaMARM, enaPC, enaMDR  out  1 each  bus tri-state enables, at most one high
- selEAB1  out  1  0=PC, 1=SR1_out
- selEAB2  out  2  00=0, 01=sext(IR[5:0]), 10=sext(IR[8:0]), 11=sext(IR[10:0])
- selPC  out  2  00=PC+1, 01=eab_out, 10=bus
- selMAR  out  1  MARM mux: 0=eab_out, 1=zext(IR[7:0])
- selMDR  out  1  0=bus, 1=memory read data
- aluControl  out  2  00=ADD, 01=AND, 10=NOT, 11=PASS(SR1)
- SR1, SR2, DR  out  3 each  register-file addresses
- instr_done  out  1  one-cycle pulse in final cycle of each instruction
- halted  out  1  high in HALT state

## Operation
- States: FETCH0, FETCH1, FETCH2, DECODE, one or more EXEC states per opcode, HALT.
- FETCH0: enaPC, ldMAR, ldPC, selPC=00.
- FETCH1: mem_en, selMDR=1; ldMDR only in the cycle mem_ready=1; advance on mem_ready.
- FETCH2: enaMDR, ldIR.
- DECODE: no strobes; branch on IR[15:12].
- ADD/AND (0001/0101): enaALU, regWE, flagWE, DR=IR[11:9], SR1=IR[8:6], SR2=IR[2:0]. IR[5] imm handled by datapath. NOT (1001): aluControl=10.
- BR (0000): ldPC, selPC=01, selEAB1=0, selEAB2=10 only if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P).
- JMP (1100): ldPC, selPC=01, selEAB1=1, selEAB2=00, SR1=IR[8:6].
- JSR/JSRR (0100): one cycle. enaPC, regWE, DR=7, ldPC, selPC=01. IR[11]=1 gives selEAB1=0/selEAB2=11; IR[11]=0 gives selEAB1=1/selEAB2=00/SR1=IR[8:6]. The register write samples the pre-update PC.
- LD/LDR/LEA: address from eab. LD uses PC+off9; LDR uses SR1=IR[8:6]+off6.
- LD/LDR flow: MAR<-eab (enaMARM, ldMAR, selMAR=0), then read (as FETCH1), then DR<-MDR (enaMDR, regWE, flagWE).
- LDI (1010): MAR<-eab, read, MAR<-MDR, read, DR<-MDR.
- LEA (1110): enaMARM, regWE, DR=IR[11:9]. No flagWE.
- ST/STR (0011/0111): MAR<-eab, then MDR<-SR (enaALU, aluControl=11, SR1=IR[11:9], selMDR=0, ldMDR), then write (mem_en, mem_we until mem_ready).
- STI (1011): MAR<-eab, read, MAR<-MDR, MDR<-SR, write.
- TRAP (1111): R7<-PC (enaPC, regWE, DR=7), then MAR<-zext vector (enaMARM, selMAR=1, ldMAR), then read, then PC<-MDR (enaMDR, ldPC, selPC=10).
- RTI (1000) and reserved (1101): enter HALT; halted=1; no strobes until reset.
- Unused outputs are 0 in every state. mem_we is never high without mem_en.

## Timing
- rst low: state forced to FETCH0 asynchronously. All outputs are held 0 while rst is low, independent of state.
- First FETCH0 strobes occur in the first cycle after rst deasserts.
- A reset mid-instruction aborts it; no partial strobe completes.
- Outputs are Moore decodes of the registered state, except ldMDR (gated by mem_ready) and BR ldPC (combinational on IR/N/Z/P).
- Memory wait: remain in the access state with mem_en held stable while mem_ready=0. A zero-wait access costs 1 cycle.
- Latency with mem_ready tied 1, counting from FETCH0:
  - ADD/AND/NOT/BR/JMP/JSR/LEA: 5 cycles
  - LD/LDR/ST/STR: 7 cycles
  - TRAP: 8 cycles
  - LDI/STI: 9 cycles
- instr_done fires in the last cycle listed above. The next cycle is FETCH0.

## Test plan
- Reset: rst=0 mid-LDI, then release. All outputs 0 during reset; FETCH0 (enaPC, ldMAR, ldPC) in the first cycle after release.
- ADD R1,R2,R3 (IR=0x1283), mem_ready=1. instr_done at cycle 5 with regWE=1, flagWE=1, DR=1, SR1=2, SR2=3, enaALU=1.
- BRz (IR=0x0405): with Z=1, ldPC=1 and selPC=01 in the exec cycle. With N=1 (Z=0), ldPC=0. Both take 5 cycles.
- LDI with mem_ready held low 3 cycles on each read: mem_en stays high, ldMDR pulses only on ready cycles, total 15 cycles, final regWE/flagWE with DR=IR[11:9].
- TRAP x25 (IR=0xF025): DR=7 with enaPC, then selMAR=1 with enaMARM, then enaMDR with ldPC and selPC=10. Total 8 cycles.
- Opcode 1101: halted=1 after DECODE, all strobes 0 for 20 cycles, recovery only after rst pulse. Across all scenarios, the one-hot check holds: enaALU+enaMARM+enaPC+enaMDR never exceeds 1.
